intersection_ctrl: RTL and testbench

//  Traffic-light controller for a two-road (NS/EW) intersection with vehicle sensors and a pedestrian button.

---
 rtl/intersection_ctrl_pkg.sv | 34 +++
 rtl/intersection_ctrl_tick_gen.sv | 34 +++
 rtl/intersection_ctrl.sv | 169 ++++++++++++++++
 tb/tb_intersection_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intersection_ctrl_pkg.sv
// Shared state codes, lamp encodings and timer sizing for the intersection controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package intersection_ctrl_pkg;

    // State codes are visible on state_o, so the numbering is part of the interface.
    typedef enum logic [2:0] {
        ST_NS_GREEN  = 3'd0,
        ST_NS_YELLOW = 3'd1,
        ST_ALLRED_NS = 3'd2,
        ST_EW_GREEN  = 3'd3,
        ST_EW_YELLOW = 3'd4,
        ST_ALLRED_EW = 3'd5,
        ST_PED_WALK  = 3'd6
    } state_t;

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    // The timer must hold the largest phase count minus one without wrapping;
    // the extra bit keeps the comparisons simple when a duration is a power of two.
    function automatic int timer_width(input int g_min, input int g_max, input int yel,
                                       input int allred, input int ped);
        int m;
        m = g_min;
        if (g_max  > m) m = g_max;
        if (yel    > m) m = yel;
        if (allred > m) m = allred;
        if (ped    > m) m = ped;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/intersection_ctrl_tick_gen.sv
// Prescaler: divides the system clock into a one-cycle tick every TICK_DIV cycles.
// Latency: tick is a combinational decode of the count register; first tick TICK_DIV cycles after reset.
// Backpressure: none; free-running.
module intersection_ctrl_tick_gen #(
    parameter int TICK_DIV = 50
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    // A 1-bit counter is kept even for TICK_DIV=1 so the vector never has zero width.
    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    // Count 0..TICK_DIV-1 and wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Tick on the last count of each period.
    always_comb begin
        tick_o = (cnt_q == LAST);
    end

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road traffic-light controller: demand-actuated greens, yellow/all-red clearance, pedestrian walk.
// Latency: lamps are a pure decode of the state register; state moves only on prescaler ticks.
// Backpressure: none; sensors and the button are sampled every cycle.
module intersection_ctrl
    import intersection_ctrl_pkg::*;
#(
    parameter int TICK_DIV    = 50,
    parameter int T_GREEN_MIN = 20,
    parameter int T_GREEN_MAX = 60,
    parameter int T_YELLOW    = 4,
    parameter int T_ALLRED    = 2,
    parameter int T_PED       = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       car_ns_i,
    input  logic       car_ew_i,
    input  logic       ped_req_i,
    output logic [1:0] light_ns_o,
    output logic [1:0] light_ew_o,
    output logic       ped_walk_o,
    output logic [2:0] state_o
);

    localparam int TW = timer_width(T_GREEN_MIN, T_GREEN_MAX, T_YELLOW, T_ALLRED, T_PED);

    // Timer values at which each phase may end (timer counts completed ticks minus one).
    localparam logic [TW-1:0] GMIN_LAST = TW'(T_GREEN_MIN - 1);
    localparam logic [TW-1:0] GMAX_LAST = TW'(T_GREEN_MAX - 1);
    localparam logic [TW-1:0] YEL_LAST  = TW'(T_YELLOW - 1);
    localparam logic [TW-1:0] AR_LAST   = TW'(T_ALLRED - 1);
    localparam logic [TW-1:0] PED_LAST  = TW'(T_PED - 1);

    state_t        state_q;
    state_t        state_nxt;
    logic [TW-1:0] timer_q;
    logic          ped_pend_q;
    logic          next_dir_q;   // 1: after the walk, serve EW; 0: serve NS
    logic          tick;
    logic          demand_ns;
    logic          demand_ew;
    logic          is_green;
    logic          walk_entry;

    intersection_ctrl_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_o (tick)
    );

    // Demand and phase qualifiers shared by the FSM and the bookkeeping registers.
    always_comb begin
        demand_ew  = car_ew_i | ped_pend_q;
        demand_ns  = car_ns_i | ped_pend_q;
        is_green   = (state_q == ST_NS_GREEN) || (state_q == ST_EW_GREEN);
        walk_entry = (state_nxt == ST_PED_WALK) && (state_q != ST_PED_WALK);
    end

    // State register; reset drops straight into all-red so no partial yellow is owed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_ALLRED_EW;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic: every transition is qualified by tick so phases stay tick-aligned.
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            ST_NS_GREEN: begin
                if (tick && (timer_q >= GMIN_LAST) && demand_ew &&
                    (!car_ns_i || (timer_q == GMAX_LAST))) begin
                    state_nxt = ST_NS_YELLOW;
                end
            end
            ST_NS_YELLOW: begin
                if (tick && (timer_q == YEL_LAST)) begin
                    state_nxt = ST_ALLRED_NS;
                end
            end
            ST_ALLRED_NS: begin
                if (tick && (timer_q == AR_LAST)) begin
                    state_nxt = ped_pend_q ? ST_PED_WALK : ST_EW_GREEN;
                end
            end
            ST_EW_GREEN: begin
                if (tick && (timer_q >= GMIN_LAST) && demand_ns &&
                    (!car_ew_i || (timer_q == GMAX_LAST))) begin
                    state_nxt = ST_EW_YELLOW;
                end
            end
            ST_EW_YELLOW: begin
                if (tick && (timer_q == YEL_LAST)) begin
                    state_nxt = ST_ALLRED_EW;
                end
            end
            ST_ALLRED_EW: begin
                if (tick && (timer_q == AR_LAST)) begin
                    state_nxt = ped_pend_q ? ST_PED_WALK : ST_NS_GREEN;
                end
            end
            ST_PED_WALK: begin
                if (tick && (timer_q == PED_LAST)) begin
                    state_nxt = next_dir_q ? ST_EW_GREEN : ST_NS_GREEN;
                end
            end
            default: begin
                state_nxt = ST_ALLRED_EW;
            end
        endcase
    end

    // Phase timer: restarts on every state change, holds at the max-green value while resting in green.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_q <= '0;
        end else if (state_nxt != state_q) begin
            timer_q <= '0;
        end else if (tick && !(is_green && (timer_q == GMAX_LAST))) begin
            timer_q <= timer_q + TW'(1);
        end
    end

    // Pedestrian request latch: consumed on entry to the walk; presses during the walk are ignored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ped_pend_q <= 1'b0;
        end else if (walk_entry) begin
            ped_pend_q <= 1'b0;
        end else if (ped_req_i && (state_q != ST_PED_WALK)) begin
            ped_pend_q <= 1'b1;
        end
    end

    // Remember which road the walk interrupted so the rotation resumes correctly afterwards.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            next_dir_q <= 1'b0;
        end else if (state_q == ST_ALLRED_NS) begin
            next_dir_q <= 1'b1;
        end else if (state_q == ST_ALLRED_EW) begin
            next_dir_q <= 1'b0;
        end
    end

    // Output decode: each road is non-red only in its own green/yellow state.
    always_comb begin
        light_ns_o = LAMP_RED;
        light_ew_o = LAMP_RED;
        ped_walk_o = 1'b0;
        state_o    = state_q;
        unique case (state_q)
            ST_NS_GREEN:  light_ns_o = LAMP_GREEN;
            ST_NS_YELLOW: light_ns_o = LAMP_YELLOW;
            ST_EW_GREEN:  light_ew_o = LAMP_GREEN;
            ST_EW_YELLOW: light_ew_o = LAMP_YELLOW;
            ST_PED_WALK:  ped_walk_o = 1'b1;
            default: begin
                light_ns_o = LAMP_RED;
                light_ew_o = LAMP_RED;
            end
        endcase
    end

endmodule

// File: tb/tb_intersection_ctrl.sv
// Self-checking bench for intersection_ctrl: directed scenarios with literal durations plus random traffic.
// A cycle-count model of the phase rules is compared against the outputs on every clock.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_intersection_ctrl;

    localparam int TD   = 2;
    localparam int GMIN = 3;
    localparam int GMAX = 6;
    localparam int TY   = 2;
    localparam int TAR  = 1;
    localparam int TPED = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       car_ns = 1'b0;
    logic       car_ew = 1'b0;
    logic       ped_req = 1'b0;
    logic [1:0] light_ns;
    logic [1:0] light_ew;
    logic       ped_walk;
    logic [2:0] state;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    intersection_ctrl #(
        .TICK_DIV    (TD),
        .T_GREEN_MIN (GMIN),
        .T_GREEN_MAX (GMAX),
        .T_YELLOW    (TY),
        .T_ALLRED    (TAR),
        .T_PED       (TPED)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .car_ns_i   (car_ns),
        .car_ew_i   (car_ew),
        .ped_req_i  (ped_req),
        .light_ns_o (light_ns),
        .light_ew_o (light_ew),
        .ped_walk_o (ped_walk),
        .state_o    (state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phase is tracked by how many cycles it has lasted; since every phase starts tick-aligned,
    // a tick falls on every TD-th cycle of the phase and k = cycles/TD is the ticks completed.
    int m_phase = 5;
    int m_n     = 1;
    int m_ret   = 0;
    bit m_pend  = 1'b0;
    bit m_valid = 1'b0;
    int m_nxt;
    int m_k;
    bit m_tk;
    bit m_dem_ew;
    bit m_dem_ns;

    always @(negedge clk) begin
        if (m_valid) begin
            chk("state", state, m_phase);
            chk("lamp_ns", light_ns, (m_phase == 0) ? 2 : (m_phase == 1) ? 1 : 0);
            chk("lamp_ew", light_ew, (m_phase == 3) ? 2 : (m_phase == 4) ? 1 : 0);
            chk("walk", ped_walk, (m_phase == 6) ? 1 : 0);
            chk("both_nonred", (light_ns != 2'b00) && (light_ew != 2'b00), 0);
            chk("walk_not_red", ped_walk && ((light_ns != 2'b00) || (light_ew != 2'b00)), 0);
        end
        // Predict the state after the coming rising edge.
        if (rst) begin
            m_valid = 1'b1;
            m_phase = 5;
            m_n     = 1;
            m_pend  = 1'b0;
            m_ret   = 0;
        end else if (m_valid) begin
            m_tk     = (m_n % TD) == 0;
            m_k      = m_n / TD;
            m_dem_ew = car_ew || m_pend;
            m_dem_ns = car_ns || m_pend;
            m_nxt    = m_phase;
            if (m_tk) begin
                case (m_phase)
                    0: if (m_k >= GMIN && m_dem_ew && (!car_ns || m_k >= GMAX)) m_nxt = 1;
                    1: if (m_k == TY) m_nxt = 2;
                    2: if (m_k == TAR) m_nxt = m_pend ? 6 : 3;
                    3: if (m_k >= GMIN && m_dem_ns && (!car_ew || m_k >= GMAX)) m_nxt = 4;
                    4: if (m_k == TY) m_nxt = 5;
                    5: if (m_k == TAR) m_nxt = m_pend ? 6 : 0;
                    6: if (m_k == TPED) m_nxt = m_ret;
                    default: m_nxt = 5;
                endcase
            end
            if (m_nxt == 6 && m_phase != 6) begin
                m_ret  = (m_phase == 2) ? 3 : 0;
                m_pend = 1'b0;
            end else if (ped_req && m_phase != 6) begin
                m_pend = 1'b1;
            end
            if (m_nxt != m_phase) begin
                m_phase = m_nxt;
                m_n     = 1;
            end else begin
                m_n++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Two reset edges; returns in the first cycle after the last one.
    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    // Called in the first cycle of a state; returns in the first cycle of the following state.
    task automatic meas(output int len, output logic [2:0] st);
        st  = state;
        len = 1;
        forever begin
            step(1);
            if (state != st) break;
            len++;
            if (len > 300) begin
                chk("meas_timeout", 1, 0);
                break;
            end
        end
    endtask

    task automatic wait_state(input logic [2:0] st);
        int cnt;
        cnt = 0;
        while (state != st && cnt < 300) begin
            step(1);
            cnt++;
        end
        if (state != st) chk("wait_state_timeout", state, st);
    endtask

    int          len;
    logic [2:0]  st;
    int          lens[6];
    logic [2:0]  sts[6];
    int          sum;
    bit          ok;

    initial begin
        // Scenario 1: no demand -> 2 cycles all-red then rest in NS green.
        do_reset();
        meas(len, st);
        chk("t1_first_state", st, 5);
        chk("t1_allred_len", len, 2);
        chk("t1_ns_green", state, 0);
        chk("t1_ns_lamp", light_ns, 2);
        chk("t1_ew_lamp", light_ew, 0);
        ok = 1'b1;
        repeat (100) begin
            step(1);
            if (state != 3'd0) ok = 1'b0;
        end
        chk("t1_rest_in_green", ok, 1);

        // Scenario 2: EW car only -> NS green at its minimum.
        car_ew = 1'b1;
        do_reset();
        meas(len, st);
        meas(len, st);
        chk("t2_ns_green_len", len, 6);
        meas(len, st);
        chk("t2_ns_yellow_len", len, 4);
        chk("t2_ns_yellow_st", st, 1);
        meas(len, st);
        chk("t2_allred_len", len, 2);
        chk("t2_ew_green", state, 3);
        chk("t2_ew_lamp", light_ew, 2);

        // Scenario 3: both roads occupied -> max greens, 36-cycle period.
        car_ns = 1'b1;
        car_ew = 1'b1;
        do_reset();
        meas(len, st);
        sum = 0;
        for (int i = 0; i < 6; i++) begin
            meas(lens[i], sts[i]);
            sum += lens[i];
            chk("t3_phase_order", sts[i], i);
        end
        chk("t3_ns_green_len", lens[0], 12);
        chk("t3_ew_green_len", lens[3], 12);
        chk("t3_period", sum, 36);

        // Scenario 4: pedestrian pulse while resting in NS green.
        car_ns = 1'b0;
        car_ew = 1'b0;
        do_reset();
        step(20);
        chk("t4_pre_green", state, 0);
        ped_req = 1'b1;
        step(1);
        ped_req = 1'b0;
        wait_state(3'd1);
        meas(len, st);
        chk("t4_yellow_len", len, 4);
        meas(len, st);
        chk("t4_allred_st", st, 2);
        chk("t4_allred_len", len, 2);
        chk("t4_walk_state", state, 6);
        chk("t4_walk_on", ped_walk, 1);
        chk("t4_walk_ns_red", light_ns, 0);
        chk("t4_walk_ew_red", light_ew, 0);
        ped_req = 1'b1;          // pressed during the walk: must be ignored
        step(1);
        ped_req = 1'b0;
        meas(len, st);
        chk("t4_walk_remaining", len, 3);
        chk("t4_then_ew_green", state, 3);
        ok = 1'b1;
        repeat (40) begin
            step(1);
            if (state != 3'd3 || ped_walk) ok = 1'b0;
        end
        chk("t4_no_second_walk", ok, 1);

        // Scenario 5: one-cycle reset in the middle of NS yellow.
        car_ew = 1'b1;
        do_reset();
        wait_state(3'd1);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t5_ns_red", light_ns, 0);
        chk("t5_ew_red", light_ew, 0);
        chk("t5_state", state, 5);
        chk("t5_walk", ped_walk, 0);
        chk("t5_timer", dut.timer_q, 0);
        meas(len, st);
        chk("t5_allred_len", len, 2);
        chk("t5_restart_green", state, 0);

        // Random traffic against the model.
        car_ew = 1'b0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) car_ns = ~car_ns;
            if ($urandom_range(0, 19) == 0) car_ew = ~car_ew;
            ped_req = ($urandom_range(0, 39) == 0);
            rst     = ($urandom_range(0, 599) == 0);
            step(1);
        end
        rst     = 1'b0;
        ped_req = 1'b0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
        $fatal(1, "watchdog");
    end

endmodule
